// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch types and constants
package rv32i_pkg;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
  typedef enum logic {IDLE, RUN} fetch_state_e;
  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry {pc,instr} FIFO whose head drives the decode interface
module fetch_fifo2
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_mem [2];
  logic r_wr, r_rd;
  logic [1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) r_mem[r_wr] <= i_din;
      r_wr <= r_wr ^ i_push;
      r_rd <= r_rd ^ i_pop;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  assign o_head = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, one-deep memory request tracking and credit-limited issue
// into a 2-entry output buffer, with redirect flush and misalignment pulse.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ILEN-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ILEN-1:0]   imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ILEN-1:0]   out_pc,
  output logic [ILEN-1:0]   out_instr,
  output logic              misalign
);
  fetch_state_e r_state, w_next;
  logic [ILEN-1:0] r_fpc, r_inflight_pc;
  logic r_inflight, r_misalign;
  logic w_run, w_pop, w_push, w_issue;
  logic [1:0] w_count;
  logic [2:0] w_occ;
  fetch_entry_t w_din, w_head;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = fetch_en ? RUN : IDLE;
  always_comb w_run = (r_state == RUN);
  assign w_pop = out_valid && out_ready;
  assign w_push = r_inflight && !redirect_valid;
  // Occupancy counts the word already in flight so a push can never overflow.
  assign w_occ = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = w_run && !redirect_valid && (w_occ < 3'(DEPTH));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fpc <= RESET_PC;
      r_inflight <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && |redirect_pc[1:0];
      r_inflight <= w_issue;
      if (redirect_valid) r_fpc <= {redirect_pc[ILEN-1:2], 2'b00};
      else if (w_issue) begin
        r_fpc <= r_fpc + 32'd4;
        r_inflight_pc <= r_fpc;
      end
    end
  assign w_din = '{pc: r_inflight_pc, instr: imem_instr};
  fetch_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign imem_addr = r_fpc[ADDR_W+1:2];
  assign out_valid = (w_count != 2'd0);
  assign out_pc = w_head.pc;
  assign out_instr = w_head.instr;
  assign misalign = r_misalign;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: cycle table for start-up/stall plus scoreboard of accepted words,
// with hand sequences for redirect, misalignment, wrap and mid-stream reset.
module tb_instr_fetch;
  import rv32i_pkg::*;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_instr = NOP;
  logic [9:0] imem_addr;
  logic out_valid, misalign;
  logic [31:0] out_pc, out_instr;
  int checks = 0, failures = 0;
  logic [63:0] q_exp [$];
  typedef struct {
    logic        en;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;
  vec_t tbl [15];
  always #5 clk = ~clk;
  instr_fetch #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign       (misalign)
  );
  always @(posedge clk) imem_instr <= 32'hA000_0000 + {22'd0, imem_addr};
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hA000_0000 + {22'd0, pc[11:2]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) q_exp.push_back({base + 32'(4 * i), word_at(base + 32'(4 * i))});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      logic [63:0] e;
      if (q_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h instr %h, none expected", out_pc, out_instr);
      end else begin
        e = q_exp.pop_front();
        chk("sb_pc", out_pc, e[63:32]);
        chk("sb_instr", out_instr, e[31:0]);
      end
    end
  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 32'(4 * (i - 2)), 32'hA000_0000 + 32'(i - 2)};
    for (int i = 7; i <= 11; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hA000_0004};
    for (int i = 12; i <= 14; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 32'(4 * (i - 7)), 32'hA000_0000 + 32'(i - 7)};
    repeat (2) step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    push_stream(32'h0, 40);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      fetch_en = tbl[i].en;
      out_ready = tbl[i].rdy;
      step();
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_pc", out_pc, tbl[i].pc);
        chk("tbl_instr", out_instr, tbl[i].instr);
      end
    end
    // redirect while one word is buffered and one is in flight
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    out_ready = 1'b0;
    step();
    chk("rd_flush", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    q_exp.delete();
    push_stream(32'h100, 12);
    out_ready = 1'b1;
    step();
    chk("rd_gap", 32'(out_valid), 32'd0);
    step();
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_pc", out_pc, 32'h100);
    chk("rd_instr", out_instr, 32'hA000_0040);
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    out_ready = 1'b0;
    step();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_flush", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    q_exp.delete();
    push_stream(32'h100, 12);
    out_ready = 1'b1;
    step();
    chk("mis_clear", 32'(misalign), 32'd0);
    step();
    chk("mis_pc", out_pc, 32'h100);
    chk("mis_instr", out_instr, 32'hA000_0040);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFC;
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    q_exp.delete();
    push_stream(32'hFFC, 12);
    out_ready = 1'b1;
    step();
    step();
    chk("wrap_pc0", out_pc, 32'hFFC);
    chk("wrap_ins0", out_instr, 32'hA000_03FF);
    step();
    chk("wrap_pc1", out_pc, 32'h1000);
    chk("wrap_ins1", out_instr, 32'hA000_0000);
    step();
    chk("wrap_pc2", out_pc, 32'h1004);
    chk("wrap_ins2", out_instr, 32'hA000_0001);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    step();
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    q_exp.delete();
    push_stream(32'h0, 12);
    rst = 1'b0;
    step();
    chk("rst2_v0", 32'(out_valid), 32'd0);
    step();
    chk("rst2_v1", 32'(out_valid), 32'd0);
    step();
    chk("rst2_valid", 32'(out_valid), 32'd1);
    chk("rst2_pc", out_pc, 32'h0);
    chk("rst2_instr", out_instr, 32'hA000_0000);
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
